// File: rtl/music_pkg.sv
// Shared types and constants for the music front-panel controller.
package music_pkg;

    // Player control state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // speedup codes understood by the tone player
    localparam logic [2:0] SPEED_NORMAL = 3'd1;
    localparam logic [2:0] SPEED_FAST   = 3'd2;

    // Default beat timing of the player (100 MHz clock)
    localparam int unsigned BEAT_CYC_NORMAL_DEF = 32'd6250002;
    localparam int unsigned BEAT_CYC_FAST_DEF   = 32'd3125002;
    localparam int unsigned SONG_BEATS_DEF      = 32'd256;

    // Next speed code on a speed-button press; anything not FAST returns to
    // FAST so the output can never sit on an undefined code.
    function automatic logic [2:0] toggle_speed(input logic [2:0] cur);
        logic [2:0] nxt;
        if (cur == SPEED_FAST) begin
            nxt = SPEED_NORMAL;
        end else begin
            nxt = SPEED_FAST;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button input path: 2-flop synchroniser, stability counter that
// accepts a new level only after DEBOUNCE_CYCLES consecutive differing
// samples, and a registered one-cycle pulse on each accepted rising level.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd2000000
) (
    input  logic clk,
    input  logic rstn,
    input  logic btn,
    output logic pulse
);
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

    logic             sync1_r;
    logic             sync2_r;
    logic             stable_r;
    logic             stable_d_r;
    logic             pulse_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_n_s;
    logic             stable_n_s;

    // Bring the asynchronous button into the clk domain
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
        end
    end

    // Count consecutive disagreeing samples; flip the stable level on the last one
    always_comb begin
        cnt_n_s    = cnt_r;
        stable_n_s = stable_r;
        if (sync2_r != stable_r) begin
            if (cnt_r == CNT_LAST) begin
                cnt_n_s    = {CNT_W{1'b0}};
                stable_n_s = ~stable_r;
            end else begin
                cnt_n_s    = cnt_r + CNT_W'(1);
                stable_n_s = stable_r;
            end
        end else begin
            cnt_n_s    = {CNT_W{1'b0}};
            stable_n_s = stable_r;
        end
    end

    // Debounce state and rising-edge pulse registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_r      <= {CNT_W{1'b0}};
            stable_r   <= 1'b0;
            stable_d_r <= 1'b0;
            pulse_r    <= 1'b0;
        end else begin
            cnt_r      <= cnt_n_s;
            stable_r   <= stable_n_s;
            stable_d_r <= stable_r;
            pulse_r    <= stable_r & ~stable_d_r;
        end
    end

    assign pulse = pulse_r;

endmodule

// File: rtl/music_ctrl.sv
// Front-panel controller for the buzzer tone player: debounced play/pause,
// stop (song restart pulse on song_rstn) and speed toggle, plus status LEDs.
// Optional build macro MUSIC_CTRL_AUTO_STOP_EN: count player beats and return
// to IDLE (with a restart pulse) once the whole song has been played.
module music_ctrl
    import music_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 32'd2000000,
    parameter int unsigned RST_CYCLES      = 32'd4,
    parameter int unsigned BEAT_CYC_NORMAL = BEAT_CYC_NORMAL_DEF,
    parameter int unsigned BEAT_CYC_FAST   = BEAT_CYC_FAST_DEF,
    parameter int unsigned SONG_BEATS      = SONG_BEATS_DEF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       btn_play,
    input  logic       btn_stop,
    input  logic       btn_speed,
    output logic       start,
    output logic [2:0] speedup,
    output logic       song_rstn,
    output logic       led_play,
    output logic       led_pause
);
    localparam int unsigned RST_W = $clog2(RST_CYCLES + 32'd1);
    localparam logic [RST_W-1:0] RST_LOAD = RST_W'(RST_CYCLES - 32'd1);

    logic             play_p_s;
    logic             stop_p_s;
    logic             speed_p_s;
    logic             end_s;
    logic             restart_s;
    state_e           state_r;
    state_e           state_n_s;
    logic             start_r;
    logic             led_play_r;
    logic             led_pause_r;
    logic [2:0]       speed_r;
    logic             song_rstn_r;
    logic [RST_W-1:0] rst_cnt_r;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_play (
        .clk(clk), .rstn(rstn), .btn(btn_play), .pulse(play_p_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop (
        .clk(clk), .rstn(rstn), .btn(btn_stop), .pulse(stop_p_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed (
        .clk(clk), .rstn(rstn), .btn(btn_speed), .pulse(speed_p_s)
    );

`ifdef MUSIC_CTRL_AUTO_STOP_EN
    localparam int unsigned BEAT_MAX = (BEAT_CYC_NORMAL > BEAT_CYC_FAST) ?
                                       BEAT_CYC_NORMAL : BEAT_CYC_FAST;
    localparam int unsigned BC_W = $clog2(BEAT_MAX + 32'd1);
    localparam int unsigned BN_W = $clog2(SONG_BEATS + 32'd1);

    logic [BC_W-1:0] beat_cyc_r;
    logic [BN_W-1:0] beat_cnt_r;
    logic [BC_W-1:0] beat_last_s;
    logic            beat_wrap_s;

    // Last cycle index of a beat at the current speed; a cycle count already at
    // or past it (after a switch to FAST) completes the beat immediately.
    always_comb begin
        beat_last_s = BC_W'(BEAT_CYC_NORMAL - 32'd1);
        if (speed_r == SPEED_FAST) begin
            beat_last_s = BC_W'(BEAT_CYC_FAST - 32'd1);
        end else begin
            beat_last_s = BC_W'(BEAT_CYC_NORMAL - 32'd1);
        end
    end

    assign beat_wrap_s = (state_r == PLAY) && (beat_cyc_r >= beat_last_s);
    assign end_s       = beat_wrap_s && (beat_cnt_r == BN_W'(SONG_BEATS - 32'd1));

    // Beat position tracking: runs in PLAY, holds in PAUSE, clears in IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cyc_r <= {BC_W{1'b0}};
            beat_cnt_r <= {BN_W{1'b0}};
        end else if (restart_s || (state_r == IDLE)) begin
            beat_cyc_r <= {BC_W{1'b0}};
            beat_cnt_r <= {BN_W{1'b0}};
        end else if (state_r == PLAY) begin
            if (beat_wrap_s) begin
                beat_cyc_r <= {BC_W{1'b0}};
                beat_cnt_r <= beat_cnt_r + BN_W'(1);
            end else begin
                beat_cyc_r <= beat_cyc_r + BC_W'(1);
            end
        end else begin
            beat_cyc_r <= beat_cyc_r;
            beat_cnt_r <= beat_cnt_r;
        end
    end
`else
    logic unused_cfg_s;

    assign end_s        = 1'b0;
    assign unused_cfg_s = ^{BEAT_CYC_NORMAL[0], BEAT_CYC_FAST[0], SONG_BEATS[0]};
`endif

    // Stop button and end-of-song share one restart path
    assign restart_s = stop_p_s | end_s;

    // Next-state logic; a restart overrides any play/pause press
    always_comb begin
        state_n_s = state_r;
        if (restart_s) begin
            state_n_s = IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (play_p_s) state_n_s = PLAY;
                    else          state_n_s = IDLE;
                end
                PLAY: begin
                    if (play_p_s) state_n_s = PAUSE;
                    else          state_n_s = PLAY;
                end
                PAUSE: begin
                    if (play_p_s) state_n_s = PLAY;
                    else          state_n_s = PAUSE;
                end
                default: state_n_s = IDLE;
            endcase
        end
    end

    // State register and registered status outputs decoded from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r     <= IDLE;
            start_r     <= 1'b0;
            led_play_r  <= 1'b0;
            led_pause_r <= 1'b0;
        end else begin
            state_r     <= state_n_s;
            start_r     <= (state_n_s == PLAY);
            led_play_r  <= (state_n_s == PLAY);
            led_pause_r <= (state_n_s == PAUSE);
        end
    end

    // Speed toggle, independent of state and of the other buttons
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            speed_r <= SPEED_NORMAL;
        end else if (speed_p_s) begin
            speed_r <= toggle_speed(speed_r);
        end else begin
            speed_r <= speed_r;
        end
    end

    // Song restart pulse: low from reset until the first edge, and for
    // RST_CYCLES cycles after each restart (a new restart reloads the count)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            song_rstn_r <= 1'b0;
            rst_cnt_r   <= {RST_W{1'b0}};
        end else if (restart_s) begin
            song_rstn_r <= 1'b0;
            rst_cnt_r   <= RST_LOAD;
        end else if (rst_cnt_r != {RST_W{1'b0}}) begin
            song_rstn_r <= 1'b0;
            rst_cnt_r   <= rst_cnt_r - RST_W'(1);
        end else begin
            song_rstn_r <= 1'b1;
            rst_cnt_r   <= {RST_W{1'b0}};
        end
    end

    assign start     = start_r;
    assign speedup   = speed_r;
    assign song_rstn = song_rstn_r;
    assign led_play  = led_play_r;
    assign led_pause = led_pause_r;

endmodule
